// File: rtl/matvec_pkg.sv
// matvec_pkg: shared types and helpers for the matrix-vector engine.
// Holds the control FSM state type and the default accumulator width rule.
package matvec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } state_e;

  // Wide enough for a full signed product plus growth from COLS additions.
  function automatic int acc_width_default(input int data_width, input int cols);
    return 2 * data_width + $clog2(cols);
  endfunction

endpackage

// File: rtl/matvec_engine_if.sv
// matvec_engine_if: host load path, control and result bundle of the engine.
// The host side uses the master modport, the engine uses the slave modport.
interface matvec_engine_if
  import matvec_pkg::*;
#(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = acc_width_default(DATA_WIDTH, COLS)
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                      a_wr_en;
  logic [ROW_W-1:0]          a_wr_row;
  logic [DATA_WIDTH-1:0]     a_wr_data;
  logic                      b_wr_en;
  logic [DATA_WIDTH-1:0]     b_wr_data;
  logic                      buf_clr;
  logic                      start;
  logic                      ready;
  logic                      busy;
  logic                      done;
  logic                      c_valid;
  logic [ROWS*ACC_WIDTH-1:0] c_out;
  logic [ROWS-1:0]           sat;
  logic                      ovf_err;

  modport master (
    output a_wr_en, a_wr_row, a_wr_data, b_wr_en, b_wr_data, buf_clr, start,
    input  ready, busy, done, c_valid, c_out, sat, ovf_err
  );

  modport slave (
    input  a_wr_en, a_wr_row, a_wr_data, b_wr_en, b_wr_data, buf_clr, start,
    output ready, busy, done, c_valid, c_out, sat, ovf_err
  );

endinterface

// File: rtl/matvec_engine_mac_cell.sv
// mac_cell: one systolic multiply-accumulate stage of the engine.
// Registers the accumulator and forwards B/enable to the next cell in the same stage.
// Macro SATURATE_EN: when defined each add clamps to the accumulator range and
// sets a sticky sat flag; when undefined accumulation wraps and sat is tied 0.
module mac_cell
  import matvec_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = acc_width_default(DATA_WIDTH, 8)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en_in,
  input  logic                         clr,
  input  logic signed [DATA_WIDTH-1:0] a_in,
  input  logic signed [DATA_WIDTH-1:0] b_in,
  output logic                         en_out,
  output logic signed [DATA_WIDTH-1:0] b_out,
  output logic signed [ACC_WIDTH-1:0]  acc,
  output logic                         sat
);

  localparam int PW = 2 * DATA_WIDTH;

  logic                         en_q;
  logic signed [DATA_WIDTH-1:0] b_q;
  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic signed [ACC_WIDTH-1:0]  acc_d;
  logic signed [PW-1:0]         prod;
  logic signed [ACC_WIDTH-1:0]  prod_ext;

`ifdef SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH:0] sum_wide;
  logic                      clamp;
  logic                      sat_q;

  // Full-precision product, sign-extended, added with one guard bit and clamped on overflow.
  always_comb begin
    prod     = PW'(a_in) * PW'(b_in);
    prod_ext = ACC_WIDTH'(prod);
    sum_wide = (ACC_WIDTH+1)'(acc_q) + (ACC_WIDTH+1)'(prod_ext);
    clamp    = sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1];
    acc_d    = sum_wide[ACC_WIDTH-1:0];
    if (clamp) acc_d = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
  end

  // The sat flag stays set once any add in this run has clamped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               sat_q <= 1'b0;
    else if (clr)             sat_q <= 1'b0;
    else if (en_in && clamp)  sat_q <= 1'b1;
  end

  assign sat = sat_q;
`else
  // Full-precision product, sign-extended, added modulo 2^ACC_WIDTH.
  always_comb begin
    prod     = PW'(a_in) * PW'(b_in);
    prod_ext = ACC_WIDTH'(prod);
    acc_d    = acc_q + prod_ext;
  end

  assign sat = 1'b0;
`endif

  // Accumulate only under the enable wavefront; B and enable move one cell per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q  <= 1'b0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (clr) begin
      en_q  <= 1'b0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      en_q <= en_in;
      b_q  <= b_in;
      if (en_in) acc_q <= acc_d;
    end
  end

  assign en_out = en_q;
  assign b_out  = b_q;
  assign acc    = acc_q;

endmodule

// File: rtl/matvec_engine.sv
// matvec_engine: signed C = A*B with per-row operand buffers, a control FSM and
// a skewed systolic chain of ROWS mac_cell instances feeding a registered result.
// Macro SATURATE_EN selects clamping accumulation (see mac_cell); default wraps.
module matvec_engine
  import matvec_pkg::*;
#(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = acc_width_default(DATA_WIDTH, COLS)
) (
  input  logic            clk,
  input  logic            rst_n,
  matvec_engine_if.slave  bus
);

  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CNT_W  = $clog2(COLS + 1);
  localparam int KIDX_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CYC_W  = (COLS + ROWS > 2) ? $clog2(COLS + ROWS) : 1;

  localparam logic [CNT_W-1:0] FULL       = CNT_W'(COLS);
  localparam logic [CYC_W-1:0] COLS_CYC   = CYC_W'(COLS);
  localparam logic [CYC_W-1:0] RUN_LAST   = CYC_W'(COLS - 1);
  localparam logic [CYC_W-1:0] DRAIN_LAST = CYC_W'(COLS + ROWS - 2);

  state_e state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;

  logic signed [DATA_WIDTH-1:0] a_mem_q [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0] b_mem_q [COLS];
  logic [CNT_W-1:0]             a_cnt_q [ROWS];
  logic [CNT_W-1:0]             b_cnt_q;
  logic                         ovf_q;

  logic                      is_idle;
  logic                      wr_open;
  logic                      all_full;
  logic [ROWS-1:0]           a_hit;

  logic                      done_q;
  logic                      c_valid_q;
  logic [ROWS*ACC_WIDTH-1:0] c_out_q;
  logic [ROWS-1:0]           sat_q;

  logic [ROWS:0]                en_chain;
  logic signed [DATA_WIDTH-1:0] b_chain [ROWS+1];
  logic signed [ACC_WIDTH-1:0]  acc_w   [ROWS];
  logic [ROWS-1:0]              cell_sat;
  logic                         unused_tail;

  assign is_idle = (state_q == IDLE);
  assign wr_open = is_idle && !bus.buf_clr;

  // Row decode for A writes and the "every buffer full" condition behind ready.
  always_comb begin
    all_full = (b_cnt_q == FULL);
    for (int r = 0; r < ROWS; r++) begin
      a_hit[r] = bus.a_wr_en && (bus.a_wr_row == ROW_W'(r));
      if (a_cnt_q[r] != FULL) all_full = 1'b0;
    end
  end

  // State and wavefront-cycle registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
    end
  end

  // Sequencing: a one-cycle clear, COLS issue cycles, ROWS-1 drain cycles, then DONE.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    case (state_q)
      IDLE:  if (bus.start && !bus.buf_clr && all_full) state_d = CLEAR;
      CLEAR: begin
        state_d = RUN;
        cyc_d   = '0;
      end
      RUN: begin
        cyc_d = cyc_q + CYC_W'(1);
        if (cyc_q == RUN_LAST) state_d = (ROWS > 1) ? DRAIN : DONE;
      end
      DRAIN: begin
        cyc_d = cyc_q + CYC_W'(1);
        if (cyc_q == DRAIN_LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write counts and the sticky drop flag; buf_clr takes priority over writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) a_cnt_q[r] <= '0;
      b_cnt_q <= '0;
      ovf_q   <= 1'b0;
    end else if (is_idle && bus.buf_clr) begin
      for (int r = 0; r < ROWS; r++) a_cnt_q[r] <= '0;
      b_cnt_q <= '0;
      ovf_q   <= 1'b0;
    end else if (wr_open) begin
      for (int r = 0; r < ROWS; r++) begin
        if (a_hit[r]) begin
          if (a_cnt_q[r] != FULL) a_cnt_q[r] <= a_cnt_q[r] + CNT_W'(1);
          else                    ovf_q      <= 1'b1;
        end
      end
      if (bus.b_wr_en) begin
        if (b_cnt_q != FULL) b_cnt_q <= b_cnt_q + CNT_W'(1);
        else                 ovf_q   <= 1'b1;
      end
    end
  end

  // Operand storage; contents survive buf_clr and reset so only counts need reloading.
  always_ff @(posedge clk) begin
    if (wr_open) begin
      for (int r = 0; r < ROWS; r++) begin
        if (a_hit[r] && a_cnt_q[r] != FULL)
          a_mem_q[r][a_cnt_q[r][KIDX_W-1:0]] <= bus.a_wr_data;
      end
      if (bus.b_wr_en && b_cnt_q != FULL)
        b_mem_q[b_cnt_q[KIDX_W-1:0]] <= bus.b_wr_data;
    end
  end

  // Head of the systolic chain: B[k] with enable during RUN cycle k.
  always_comb begin
    en_chain[0] = (state_q == RUN);
    b_chain[0]  = '0;
    if (state_q == RUN) b_chain[0] = b_mem_q[cyc_q[KIDX_W-1:0]];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [CYC_W-1:0]             a_idx;
    logic signed [DATA_WIDTH-1:0] a_sel;

    // Cell r sees B[k] in cycle k+r, so it reads A[r][cycle-r].
    always_comb begin
      a_idx = cyc_q - CYC_W'(r);
      a_sel = '0;
      if (a_idx < COLS_CYC) a_sel = a_mem_q[r][a_idx[KIDX_W-1:0]];
    end

    mac_cell #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_in  (en_chain[r]),
      .clr    (state_q == CLEAR),
      .a_in   (a_sel),
      .b_in   (b_chain[r]),
      .en_out (en_chain[r+1]),
      .b_out  (b_chain[r+1]),
      .acc    (acc_w[r]),
      .sat    (cell_sat[r])
    );
  end

  assign unused_tail = ^{en_chain[ROWS], b_chain[ROWS]};

  // Result register: invalidated by CLEAR, captured in DONE and held until the next run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q    <= 1'b0;
      c_valid_q <= 1'b0;
      c_out_q   <= '0;
      sat_q     <= '0;
    end else begin
      done_q <= (state_q == DONE);
      if (state_q == CLEAR) begin
        c_valid_q <= 1'b0;
        sat_q     <= '0;
      end else if (state_q == DONE) begin
        c_valid_q <= 1'b1;
        sat_q     <= cell_sat;
        for (int r = 0; r < ROWS; r++) c_out_q[r*ACC_WIDTH +: ACC_WIDTH] <= acc_w[r];
      end
    end
  end

  assign bus.ready   = is_idle && all_full;
  assign bus.busy    = !is_idle;
  assign bus.done    = done_q;
  assign bus.c_valid = c_valid_q;
  assign bus.c_out   = c_out_q;
  assign bus.sat     = sat_q;
  assign bus.ovf_err = ovf_q;

endmodule

// File: tb/tb_matvec_engine.sv
// tb_matvec_engine: drives two engines (default accumulator and 16-bit accumulator)
// with identical traffic and compares them against a plain dot-product model.
module tb_matvec_engine;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int DW   = 8;
  localparam int ACC0 = 2 * DW + $clog2(COLS);
  localparam int ACC1 = 16;
  localparam int DONE_LAT = COLS + ROWS + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          a_wr_en = 1'b0;
  logic [2:0]    a_wr_row = '0;
  logic [DW-1:0] a_wr_data = '0;
  logic          b_wr_en = 1'b0;
  logic [DW-1:0] b_wr_data = '0;
  logic          buf_clr = 1'b0;
  logic          start = 1'b0;

  matvec_engine_if #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(ACC0)) bus0 ();
  matvec_engine_if #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(ACC1)) bus1 ();

  assign bus0.a_wr_en = a_wr_en;   assign bus1.a_wr_en = a_wr_en;
  assign bus0.a_wr_row = a_wr_row; assign bus1.a_wr_row = a_wr_row;
  assign bus0.a_wr_data = a_wr_data; assign bus1.a_wr_data = a_wr_data;
  assign bus0.b_wr_en = b_wr_en;   assign bus1.b_wr_en = b_wr_en;
  assign bus0.b_wr_data = b_wr_data; assign bus1.b_wr_data = b_wr_data;
  assign bus0.buf_clr = buf_clr;   assign bus1.buf_clr = buf_clr;
  assign bus0.start = start;       assign bus1.start = start;

  matvec_engine #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
  );

  matvec_engine #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(ACC1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
  );

  int checks = 0;
  int errors = 0;
  int A [ROWS][COLS];
  int B [COLS];

  // Reference: dot product of row r, added in k order into a w-bit signed accumulator.
  function automatic int modelRow(input int r, input int w, output bit s);
    longint acc = 0;
    longint hi = (longint'(1) << (w - 1)) - 1;
    longint lo = -(longint'(1) << (w - 1));
    longint m  = longint'(1) << w;
    s = 1'b0;
    for (int k = 0; k < COLS; k++) begin
      acc += longint'(A[r][k]) * longint'(B[k]);
`ifdef SATURATE_EN
      if (acc > hi) begin acc = hi; s = 1'b1; end
      if (acc < lo) begin acc = lo; s = 1'b1; end
`endif
    end
`ifndef SATURATE_EN
    acc = acc % m;
    if (acc < 0) acc += m;
    if (acc > hi) acc -= m;
`endif
    return int'(acc);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Clear counts, then load A row by row and B; shortRow (if >= 0) gets one entry fewer.
  task automatic applyStimulus(input int shortRow);
    buf_clr = 1'b1; tick(); buf_clr = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < COLS; k++) begin
        if (r == shortRow && k == COLS - 1) continue;
        a_wr_en = 1'b1; a_wr_row = 3'(r); a_wr_data = DW'(A[r][k]);
        tick();
        a_wr_en = 1'b0;
      end
    for (int k = 0; k < COLS; k++) begin
      b_wr_en = 1'b1; b_wr_data = DW'(B[k]);
      tick();
      b_wr_en = 1'b0;
    end
  endtask

  // Pulse start and count cycles until done, bounded.
  task automatic runAndWait(output int cycles);
    start = 1'b1; tick(); start = 1'b0;
    cycles = 0;
    while (bus0.done !== 1'b1 && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({bus0.ready, bus0.busy, bus0.done, bus0.c_valid, bus0.ovf_err, bus0.sat} !== '0 || bus0.c_out !== '0) begin
      errors++;
      $display("[TB] FAIL reset_dut0 got ctl=%b c_out=%h, required all zero",
               {bus0.ready, bus0.busy, bus0.done, bus0.c_valid, bus0.ovf_err}, bus0.c_out);
    end
    checks++;
    if ({bus1.ready, bus1.busy, bus1.done, bus1.c_valid, bus1.ovf_err, bus1.sat} !== '0 || bus1.c_out !== '0) begin
      errors++;
      $display("[TB] FAIL reset_dut1 got ctl=%b c_out=%h, required all zero",
               {bus1.ready, bus1.busy, bus1.done, bus1.c_valid, bus1.ovf_err}, bus1.c_out);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int cyc, g0, g1, e0, e1;
    bit s0, s1;
    for (int r = 0; r < ROWS; r++) for (int k = 0; k < COLS; k++) A[r][k] = 1;
    for (int k = 0; k < COLS; k++) B[k] = k + 1;
    applyStimulus(-1);
    checks++;
    if (bus0.ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready got %b required 1", bus0.ready); end
    runAndWait(cyc);
    checks++;
    if (cyc != DONE_LAT) begin errors++; $display("[TB] FAIL basic_latency got %0d required %0d", cyc, DONE_LAT); end
    for (int r = 0; r < ROWS; r++) begin
      e0 = modelRow(r, ACC0, s0); e1 = modelRow(r, ACC1, s1);
      g0 = int'($signed(bus0.c_out[r*ACC0 +: ACC0])); g1 = int'($signed(bus1.c_out[r*ACC1 +: ACC1]));
      checks += 2;
      if (g0 != e0 || e0 != 36) begin errors++; $display("[TB] FAIL basic_row%0d got %0d required 36", r, g0); end
      if (g1 != e1 || bus1.sat[r] !== s1) begin errors++; $display("[TB] FAIL basic16_row%0d got %0d/%b required %0d/%b", r, g1, bus1.sat[r], e1, s1); end
    end
    tick(); tick(); tick();
    checks++;
    if ({bus0.done, bus0.busy, bus0.c_valid, bus0.ready} !== 4'b0011) begin
      errors++; $display("[TB] FAIL basic_hold got done/busy/c_valid/ready=%b required 0011", {bus0.done, bus0.busy, bus0.c_valid, bus0.ready});
    end
    checks++;
    if (int'($signed(bus0.c_out[0 +: ACC0])) != 36) begin
      errors++; $display("[TB] FAIL basic_hold_c_out got %0d required 36", $signed(bus0.c_out[0 +: ACC0]));
    end
  endtask

  task automatic test_extreme();
    int cyc, g0, g1, e0, e1;
    bit s0, s1;
    for (int r = 0; r < ROWS; r++) for (int k = 0; k < COLS; k++) A[r][k] = -128;
    for (int k = 0; k < COLS; k++) B[k] = -128;
    applyStimulus(-1);
    runAndWait(cyc);
    checks++;
    if (cyc != DONE_LAT) begin errors++; $display("[TB] FAIL extreme_latency got %0d required %0d", cyc, DONE_LAT); end
    for (int r = 0; r < ROWS; r++) begin
      e0 = modelRow(r, ACC0, s0); e1 = modelRow(r, ACC1, s1);
      g0 = int'($signed(bus0.c_out[r*ACC0 +: ACC0])); g1 = int'($signed(bus1.c_out[r*ACC1 +: ACC1]));
      checks += 2;
      if (g0 != e0 || bus0.sat[r] !== s0) begin errors++; $display("[TB] FAIL extreme_row%0d got %0d/%b required %0d/%b", r, g0, bus0.sat[r], e0, s0); end
      if (g1 != e1 || bus1.sat[r] !== s1) begin errors++; $display("[TB] FAIL extreme16_row%0d got %0d/%b required %0d/%b", r, g1, bus1.sat[r], e1, s1); end
    end
  endtask

  // Random data, then an immediate second run on the same buffers.
  task automatic test_random_back_to_back();
    int cyc, g0, g1, e0, e1;
    bit s0, s1;
    for (int it = 0; it < 3; it++) begin
      for (int r = 0; r < ROWS; r++) for (int k = 0; k < COLS; k++) A[r][k] = int'($urandom_range(0, 255)) - 128;
      for (int k = 0; k < COLS; k++) B[k] = int'($urandom_range(0, 255)) - 128;
      applyStimulus(-1);
      for (int pass = 0; pass < 2; pass++) begin
        runAndWait(cyc);
        checks++;
        if (cyc != DONE_LAT) begin errors++; $display("[TB] FAIL random_latency it%0d pass%0d got %0d required %0d", it, pass, cyc, DONE_LAT); end
        for (int r = 0; r < ROWS; r++) begin
          e0 = modelRow(r, ACC0, s0); e1 = modelRow(r, ACC1, s1);
          g0 = int'($signed(bus0.c_out[r*ACC0 +: ACC0])); g1 = int'($signed(bus1.c_out[r*ACC1 +: ACC1]));
          checks += 2;
          if (g0 != e0) begin errors++; $display("[TB] FAIL random_it%0d_row%0d got %0d required %0d", it, r, g0, e0); end
          if (g1 != e1 || bus1.sat[r] !== s1) begin errors++; $display("[TB] FAIL random16_it%0d_row%0d got %0d/%b required %0d/%b", it, r, g1, bus1.sat[r], e1, s1); end
        end
      end
    end
  endtask

  task automatic test_not_ready_and_ovf();
    applyStimulus(3);
    checks++;
    if (bus0.ready !== 1'b0) begin errors++; $display("[TB] FAIL short_ready got %b required 0", bus0.ready); end
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus0.busy !== 1'b0) begin errors++; $display("[TB] FAIL short_busy cycle%0d got %b required 0", i, bus0.busy); end
      tick();
    end
    checks++;
    if (bus0.ovf_err !== 1'b0) begin errors++; $display("[TB] FAIL short_ovf_quiet got %b required 0", bus0.ovf_err); end
    b_wr_en = 1'b1; b_wr_data = 8'h11; tick(); b_wr_en = 1'b0;
    checks++;
    if (bus0.ovf_err !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set got %b required 1", bus0.ovf_err); end
    buf_clr = 1'b1; tick(); buf_clr = 1'b0;
    checks++;
    if (bus0.ovf_err !== 1'b0 || bus0.ready !== 1'b0) begin
      errors++; $display("[TB] FAIL ovf_clear got ovf/ready=%b%b required 00", bus0.ovf_err, bus0.ready);
    end
  endtask

  task automatic test_writes_during_run();
    int cyc, g0, g1, e0, e1;
    bit s0, s1;
    for (int r = 0; r < ROWS; r++) for (int k = 0; k < COLS; k++) A[r][k] = r + 1;
    for (int k = 0; k < COLS; k++) B[k] = k + 1;
    applyStimulus(-1);
    start = 1'b1; tick(); start = 1'b0;
    cyc = 0;
    while (bus0.done !== 1'b1 && cyc < 200) begin
      a_wr_en = 1'b1; a_wr_row = 3'($urandom_range(0, 7)); a_wr_data = DW'($urandom);
      b_wr_en = 1'b1; b_wr_data = DW'($urandom);
      tick();
      cyc++;
    end
    a_wr_en = 1'b0; b_wr_en = 1'b0;
    checks++;
    if (cyc != DONE_LAT) begin errors++; $display("[TB] FAIL busywr_latency got %0d required %0d", cyc, DONE_LAT); end
    checks++;
    if (bus0.ovf_err !== 1'b0) begin errors++; $display("[TB] FAIL busywr_ovf got %b required 0", bus0.ovf_err); end
    for (int r = 0; r < ROWS; r++) begin
      e0 = modelRow(r, ACC0, s0); e1 = modelRow(r, ACC1, s1);
      g0 = int'($signed(bus0.c_out[r*ACC0 +: ACC0])); g1 = int'($signed(bus1.c_out[r*ACC1 +: ACC1]));
      checks += 2;
      if (g0 != e0 || e0 != 36 * (r + 1)) begin errors++; $display("[TB] FAIL busywr_row%0d got %0d required %0d", r, g0, 36 * (r + 1)); end
      if (g1 != e1) begin errors++; $display("[TB] FAIL busywr16_row%0d got %0d required %0d", r, g1, e1); end
    end
  endtask

  task automatic test_reset_midrun();
    int cyc, g0, e0;
    bit s0;
    for (int r = 0; r < ROWS; r++) for (int k = 0; k < COLS; k++) A[r][k] = int'($urandom_range(0, 255)) - 128;
    for (int k = 0; k < COLS; k++) B[k] = int'($urandom_range(0, 255)) - 128;
    applyStimulus(-1);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    checks++;
    if (bus0.busy !== 1'b1) begin errors++; $display("[TB] FAIL midrun_busy got %b required 1", bus0.busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus0.ready, bus0.busy, bus0.done, bus0.c_valid, bus0.ovf_err, bus0.sat} !== '0 || bus0.c_out !== '0) begin
      errors++; $display("[TB] FAIL midrun_reset got ctl=%b c_out=%h required all zero",
                         {bus0.ready, bus0.busy, bus0.done, bus0.c_valid, bus0.ovf_err}, bus0.c_out);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus0.ready !== 1'b0) begin errors++; $display("[TB] FAIL midrun_counts got ready %b required 0", bus0.ready); end
    applyStimulus(-1);
    runAndWait(cyc);
    checks++;
    if (cyc != DONE_LAT) begin errors++; $display("[TB] FAIL midrun_latency got %0d required %0d", cyc, DONE_LAT); end
    for (int r = 0; r < ROWS; r++) begin
      e0 = modelRow(r, ACC0, s0);
      g0 = int'($signed(bus0.c_out[r*ACC0 +: ACC0]));
      checks++;
      if (g0 != e0) begin errors++; $display("[TB] FAIL midrun_row%0d got %0d required %0d", r, g0, e0); end
    end
  endtask

  initial begin
    $display("[TB] matvec_engine bench start");
    test_reset();
    test_basic();
    test_extreme();
    test_random_back_to_back();
    test_not_ready_and_ovf();
    test_writes_during_run();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matvec_engine.md
# matvec_engine

Parametrised signed matrix–vector multiply engine, C = A·B, with A of size ROWS×COLS and B of length COLS. Generalises the fixed 8-lane MAC array with FIFO feed into a self-contained block. It has per-row operand buffers, a control FSM, skewed systolic issue down a chain of ROWS MAC cells, and a registered result vector with a done pulse. It sits between the host load path and result consumers.

## Interface
- ROWS, 8, number of output rows and MAC cells
- COLS, 8, vector length and buffer depth per row
- DATA_WIDTH, 8, signed operand width
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(COLS), signed accumulator width
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- a_wr_en  in  1  append a_wr_data to row a_wr_row buffer
- a_wr_row  in  $clog2(ROWS)  target row
- a_wr_data  in  DATA_WIDTH  A element
- b_wr_en  in  1  append b_wr_data to B buffer
- b_wr_data  in  DATA_WIDTH  B element
- buf_clr  in  1  zero all buffer write counts
- start  in  1  request a multiply
- ready  out  1  IDLE and every buffer holds COLS entries
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle completion pulse
- c_valid  out  1  c_out holds a completed result
- c_out  out  ROWS*ACC_WIDTH  row r at bits [r*ACC_WIDTH +: ACC_WIDTH]
- sat  out  ROWS  per-row saturation flag
- ovf_err  out  1  sticky, a write was dropped

## Operation
- Buffers: ROWS A buffers and one B buffer, each COLS deep. Each has a write count 0..COLS. A write stores at index count and increments count.
- Writes are accepted only in IDLE with count<COLS. Otherwise the write is dropped. A drop while in IDLE with count==COLS sets ovf_err. Writes while busy are silently dropped.
- buf_clr (IDLE only) zeros all counts and clears ovf_err. Contents are retained. buf_clr beats a same-cycle write and a same-cycle start.
- Buffers persist across runs, so A can be reused after buf_clr plus a full reload.
- FSM states: IDLE → CLEAR → RUN → DRAIN → DONE → IDLE.
  - IDLE: start && ready → CLEAR. start without ready is ignored; no error.
  - CLEAR (1 cycle): zero all accumulators and sat, and deassert c_valid.
  - RUN (COLS cycles, k=0..COLS-1): issue B[k] with enable into cell 0. B and enable ripple one cell per cycle, so cell r accumulates A[r][k]*B[k] in global cycle k+r.
  - DRAIN (ROWS-1 cycles): the enable wavefront finishes the lower cells.
  - DONE (1 cycle): done=1, c_valid=1, c_out loaded from the accumulators → IDLE.
- c_out and c_valid stay stable until the next accepted start.
- Arithmetic: full 2*DATA_WIDTH signed product, sign-extended to ACC_WIDTH, then added. Overflow behaviour is set by the configuration macro.

## Timing
- Reset values: every output 0; FSM IDLE; counts, accumulators and ovf_err 0.
- Buffer read latency is 0 (register-array index).
- The MAC cell registers the accumulator and the forwarded B/enable in one stage.
- done asserts exactly COLS+ROWS+1 cycles after the edge that samples an accepted start.
- The cycle after DONE: busy=0, and ready reflects the buffer counts.
- Reset mid-run: immediate return to IDLE with all outputs 0. Buffer counts also clear.

## Configuration
- SATURATE_EN defined:
  - Each add clamps to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1].
  - Any clamp sets that row's sat bit until the next CLEAR.
- SATURATE_EN undefined:
  - Accumulation wraps modulo 2^ACC_WIDTH.
  - sat is tied 0.

## Structure
- Package matvec_pkg holds:
  - the state enum type (IDLE, CLEAR, RUN, DRAIN, DONE);
  - the default-width helper function for ACC_WIDTH.
- Sub-module mac_cell, instantiated ROWS times in a generate chain:
  - inputs: en_in, clr, a_in, b_in;
  - outputs: en_out, b_out (registered forwards), acc, sat.

## Test plan
- Defaults, A all 1, B = 1..8 → every row 36; done 17 cycles after start; c_valid held.
- A all −128, B all −128 → every row 131072, no sat.
- ACC_WIDTH=16, same data as the previous case → rows 0 with sat=0 without SATURATE_EN; rows 32767 with sat all 1 when SATURATE_EN is defined.
- start with row 3 holding 7 entries → ignored, busy stays 0. Then write a 9th B element after B is full → ovf_err=1; buf_clr clears it.
- A[r][k]=r+1, B=1..8, a_wr_en/b_wr_en pulsed during RUN → writes dropped, row r = 36·(r+1), ovf_err stays 0.
- rst_n low in RUN cycle 3 → all outputs 0 within the same cycle, counts 0, ready 0. After reload and start, the result is correct.
